shiftout_scheduler: RTL and testbench

- Shares one `shiftout` serial engine between NUM_REQ requesters using round-robin arbitration.
- Each granted request supplies a WIDTH-bit word. The scheduler captures it, holds it on the engine's parallel input, pulses the engine's restart, and waits for the engine's done.
- Sits between the `shiftout` instance and client logic such as LED/display drivers. A watchdog keeps a hung engine from stalling every requester.

---
 rtl/shiftout_scheduler.sv | 115 +++++++++++
 tb/tb_shiftout_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftout_scheduler.sv
// Round-robin scheduler sharing one shiftout serial engine between NUM_REQ requesters.
// Captures the granted word, restarts the engine, and waits for done under a watchdog.
module shiftout_scheduler #(
   parameter  int NUM_REQ        = 4,
   parameter  int WIDTH          = 16,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int GW             = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
   localparam int WD_W           = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic [NUM_REQ-1:0]       req_valid_in,
   input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
   output logic [NUM_REQ-1:0]       req_ack_out,
   output logic [WIDTH-1:0]         shift_bits_out,
   output logic                     shift_start_out,
   input  logic                     shift_done_in,
   output logic                     busy_out,
   output logic [GW-1:0]            grant_id_out,
   output logic                     complete_out,
   output logic                     timeout_out
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT_LOW,
      ST_WAIT_DONE
   } state_t;

   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   state_t               r_state;
   logic [GW-1:0]        r_last;
   logic [GW-1:0]        r_grant;
   logic [WIDTH-1:0]     r_bits;
   logic [NUM_REQ-1:0]   r_ack;
   logic                 r_start;
   logic                 r_complete;
   logic                 r_timeout;
   logic [WD_W-1:0]      r_wdog;
   logic [GW-1:0]        w_sel;

   // Scan from r_last+NUM_REQ down to r_last+1 so the nearest requester after r_last wins.
   always_comb begin
      // NOTE: default first so every path assigns w_sel and no latch is inferred.
      w_sel = r_last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         int w_idx;
         w_idx = (int'(r_last) + k) % NUM_REQ;
         if (req_valid_in[w_idx]) w_sel = GW'(w_idx);
      end
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state    <= ST_IDLE;
         r_last     <= GW'(NUM_REQ - 1);
         r_grant    <= '0;
         r_bits     <= '0;
         r_ack      <= '0;
         r_start    <= 1'b0;
         r_complete <= 1'b0;
         r_timeout  <= 1'b0;
         r_wdog     <= '0;
      end else begin
         r_ack      <= '0;
         r_start    <= 1'b0;
         r_complete <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|req_valid_in) begin
                  r_ack[w_sel] <= 1'b1;
                  r_bits       <= req_data_in[int'(w_sel)*WIDTH +: WIDTH];
                  r_grant      <= w_sel;
                  r_last       <= w_sel;
                  r_state      <= ST_LOAD;
               end
            end
            ST_LOAD: r_state <= ST_START;
            ST_START: begin
               r_start <= 1'b1;
               r_wdog  <= '0;
               r_state <= ST_WAIT_LOW;
            end
            ST_WAIT_LOW, ST_WAIT_DONE: begin
               // A real completion on the last watchdog cycle still counts as a completion.
               if (r_state == ST_WAIT_DONE && shift_done_in) begin
                  r_complete <= 1'b1;
                  r_state    <= ST_IDLE;
               end else if (r_wdog == WD_MAX) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
                  if (r_state == ST_WAIT_LOW && !shift_done_in) r_state <= ST_WAIT_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ack_out     = r_ack;
   assign shift_bits_out  = r_bits;
   assign shift_start_out = r_start;
   assign busy_out        = (r_state != ST_IDLE);
   assign grant_id_out    = r_grant;
   assign complete_out    = r_complete;
   assign timeout_out     = r_timeout;

endmodule

// File: tb/tb_shiftout_scheduler.sv
// Directed bench for shiftout_scheduler with a small behavioural shiftout engine.
module tb_shiftout_scheduler;

   localparam int NR = 4;
   localparam int W  = 16;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*W-1:0]   req_data = '0;
   logic [NR-1:0]     req_ack_out;
   logic [W-1:0]      shift_bits_out;
   logic              shift_start_out;
   logic              shift_done;
   logic              busy_out;
   logic [1:0]        grant_id_out;
   logic              complete_out;
   logic              timeout_out;

   shiftout_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk_in          (clk),
      .reset_in        (reset),
      .req_valid_in    (req_valid),
      .req_data_in     (req_data),
      .req_ack_out     (req_ack_out),
      .shift_bits_out  (shift_bits_out),
      .shift_start_out (shift_start_out),
      .shift_done_in   (shift_done),
      .busy_out        (busy_out),
      .grant_id_out    (grant_id_out),
      .complete_out    (complete_out),
      .timeout_out     (timeout_out)
   );

   always #5 clk = ~clk;

   // Engine model: restart drops done, which rises again five cycles later.
   typedef enum int {ENG_AUTO, ENG_STUCK_LOW, ENG_MANUAL} eng_mode_t;
   eng_mode_t eng_mode = ENG_AUTO;
   logic      man_done = 1'b0;
   logic      eng_done = 1'b1;
   int        eng_cnt  = 0;

   always @(posedge clk) begin
      if (shift_start_out) begin
         eng_done <= 1'b0;
         eng_cnt  <= 5;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) eng_done <= 1'b1;
      end
   end

   assign shift_done = (eng_mode == ENG_MANUAL)    ? man_done :
                       (eng_mode == ENG_STUCK_LOW) ? 1'b0     : eng_done;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_ack, n_start, n_complete, n_timeout, n_bits_changed;
   int         cyc = 0;
   int         grant_q[$];
   bit         in_xfer = 1'b0;
   bit         drop_on_ack = 1'b1;
   logic [W-1:0] xfer_bits;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      n_ack = 0; n_start = 0; n_complete = 0; n_timeout = 0; n_bits_changed = 0;
      grant_q.delete();
   endtask

   // Advance to the next falling edge, log DUT events, and drop acked requests.
   task automatic run_cycle();
      @(negedge clk);
      cyc++;
      if (req_ack_out != '0) begin
         n_ack++;
         for (int i = 0; i < NR; i++) if (req_ack_out[i]) grant_q.push_back(i);
      end
      if (shift_start_out) begin
         n_start++;
         in_xfer   = 1'b1;
         xfer_bits = shift_bits_out;
      end else if (in_xfer && shift_bits_out != xfer_bits) begin
         n_bits_changed++;
      end
      if (complete_out) n_complete++;
      if (timeout_out)  n_timeout++;
      if (complete_out || timeout_out) in_xfer = 1'b0;
      if (drop_on_ack) req_valid = req_valid & ~req_ack_out;
   endtask

   task automatic wait_event(input string tag, input int kind, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         run_cycle();
         case (kind)
            0:       seen = shift_start_out;
            1:       seen = complete_out;
            default: seen = timeout_out;
         endcase
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      run_cycle();
      run_cycle();
      reset   = 1'b0;
      in_xfer = 1'b0;
      clear_stats();
   endtask

   task automatic set_data(input int idx, input logic [W-1:0] val);
      req_data[idx*W +: W] = val;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ack"},      32'(req_ack_out),     32'd0);
      check({pfx, "_bits"},     32'(shift_bits_out),  32'd0);
      check({pfx, "_start"},    32'(shift_start_out), 32'd0);
      check({pfx, "_busy"},     32'(busy_out),        32'd0);
      check({pfx, "_grant"},    32'(grant_id_out),    32'd0);
      check({pfx, "_complete"}, 32'(complete_out),    32'd0);
      check({pfx, "_timeout"},  32'(timeout_out),     32'd0);
   endtask

   initial begin
      int c0;
      @(negedge clk);

      // Single request: cycle-exact ack, load and start.
      do_reset();
      check_all_zero("reset");
      set_data(0, 16'hF335);
      req_valid = 4'b0001;
      run_cycle();
      check("t1_ack",   32'(req_ack_out),    32'h1);
      check("t1_grant", 32'(grant_id_out),   32'd0);
      check("t1_bits",  32'(shift_bits_out), 32'hF335);
      check("t1_busy",  32'(busy_out),       32'd1);
      run_cycle();
      check("t1_no_start_early", 32'(shift_start_out), 32'd0);
      run_cycle();
      check("t1_start_ack2", 32'(shift_start_out), 32'd1);
      wait_event("t1_complete", 1, 40);
      check("t1_idle_after",   32'(busy_out), 32'd0);
      check("t1_start_count",  32'(n_start),  32'd1);
      check("t1_ack_count",    32'(n_ack),    32'd1);

      // Contention: requesters 0,1,2 together.
      do_reset();
      set_data(0, 16'h1111); set_data(1, 16'h2222); set_data(2, 16'h3333);
      req_valid = 4'b0111;
      for (int i = 0; i < 300 && n_complete < 3; i++) run_cycle();
      check("t2_completes",   32'(n_complete),     32'd3);
      check("t2_queue_len",   32'(grant_q.size()), 32'd3);
      check("t2_grant0",      32'(grant_q[0]),     32'd0);
      check("t2_grant1",      32'(grant_q[1]),     32'd1);
      check("t2_grant2",      32'(grant_q[2]),     32'd2);
      check("t2_starts",      32'(n_start),        32'd3);
      check("t2_bits_stable", 32'(n_bits_changed), 32'd0);

      // Fairness: requesters 1 and 3 keep requesting.
      do_reset();
      drop_on_ack = 1'b0;
      req_valid = 4'b1010;
      for (int i = 0; i < 300 && n_ack < 4; i++) begin
         run_cycle();
         if (n_ack >= 4) req_valid = '0;
      end
      for (int i = 0; i < 300 && n_complete < 4; i++) run_cycle();
      drop_on_ack = 1'b1;
      check("t3_queue_len", 32'(grant_q.size()), 32'd4);
      check("t3_grant0",    32'(grant_q[0]),     32'd1);
      check("t3_grant1",    32'(grant_q[1]),     32'd3);
      check("t3_grant2",    32'(grant_q[2]),     32'd1);
      check("t3_grant3",    32'(grant_q[3]),     32'd3);

      // Stale done: done already high when the engine is restarted.
      do_reset();
      eng_mode = ENG_MANUAL;
      man_done = 1'b1;
      set_data(2, 16'hABCD);
      req_valid = 4'b0100;
      wait_event("t4_start", 0, 10);
      for (int i = 0; i < 4; i++) run_cycle();
      check("t4_no_stale_complete", 32'(n_complete), 32'd0);
      check("t4_busy_stale",        32'(busy_out),   32'd1);
      man_done = 1'b0;
      run_cycle();
      run_cycle();
      check("t4_no_complete_low", 32'(n_complete), 32'd0);
      man_done = 1'b1;
      wait_event("t4_complete", 1, 5);
      check("t4_no_timeout", 32'(n_timeout),      32'd0);
      check("t4_bits",       32'(shift_bits_out), 32'hABCD);
      eng_mode = ENG_AUTO;

      // Watchdog: engine never finishes; pending request served afterwards.
      do_reset();
      eng_mode = ENG_STUCK_LOW;
      set_data(1, 16'h1234); set_data(3, 16'h4321);
      req_valid = 4'b1010;
      wait_event("t5_start", 0, 10);
      c0 = cyc;
      wait_event("t5_timeout", 2, 30);
      check("t5_timeout_delay", 32'(cyc - c0),   32'd16);
      check("t5_no_complete",   32'(n_complete), 32'd0);
      check("t5_idle_timeout",  32'(busy_out),   32'd0);
      eng_mode = ENG_AUTO;
      run_cycle();
      check("t5_regrant_ack",  32'(req_ack_out),    32'h8);
      check("t5_regrant_bits", 32'(shift_bits_out), 32'h4321);
      wait_event("t5_complete", 1, 40);
      check("t5_timeouts", 32'(n_timeout),  32'd1);
      check("t5_first_grant", 32'(grant_q[0]), 32'd1);

      // Reset while waiting for done.
      do_reset();
      set_data(2, 16'h5A5A);
      req_valid = 4'b0100;
      wait_event("t6_start", 0, 10);
      run_cycle();
      run_cycle();
      check("t6_busy_before", 32'(busy_out), 32'd1);
      reset = 1'b1;
      run_cycle();
      check_all_zero("t6_after_reset");
      reset   = 1'b0;
      in_xfer = 1'b0;
      clear_stats();
      for (int i = 0; i < 10; i++) run_cycle();
      check("t6_no_complete", 32'(n_complete), 32'd0);
      check("t6_no_start",    32'(n_start),    32'd0);
      set_data(0, 16'h0F0F); set_data(3, 16'hF0F0);
      req_valid = 4'b1001;
      run_cycle();
      check("t6_prio_ack",  32'(req_ack_out),    32'h1);
      check("t6_prio_bits", 32'(shift_bits_out), 32'h0F0F);
      for (int i = 0; i < 100 && n_complete < 2; i++) run_cycle();
      check("t6_completes", 32'(n_complete), 32'd2);
      check("t6_order",     32'(grant_q[1]), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
